// File: rtl/cam_pkg.sv
// Shared camera timing definitions: exposure FSM states and exposure-time limits.
// Used by both the exposure timer and the exposure controller.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPOSE  = 2'd1,
        READOUT = 2'd2
    } exp_state_t;

    localparam logic [4:0] EXP_MIN  = 5'd2;
    localparam logic [4:0] EXP_MAX  = 5'd30;
    localparam logic [4:0] EXP_INIT = 5'd15;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: tick is high for one Clk every CLK_PER_MS cycles.
// clr restarts the count so the first tick lands CLK_PER_MS cycles after the clearing edge.
module ms_tick_gen #(
    parameter int CLK_PER_MS = 1000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLK_PER_MS - 1);

    logic [15:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/exposure_timer.sv
// Exposure timer: times an exposure of Exp_time ms, then a fixed readout window,
// pulsing Ovf5 at end of exposure and Ovf4 at end of readout. State visible on State_dbg.
module exposure_timer
    import cam_pkg::*;
#(
    parameter int CLK_PER_MS  = 1000,
    parameter int READOUT_CYC = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start_Timer,
    input  logic       Init,
    input  logic       Exp_increase,
    input  logic       Exp_decrease,
    output logic       Ovf5,
    output logic       Ovf4,
    output logic [4:0] Exp_time,
    output logic       Busy,
    output exp_state_t State_dbg
);

    localparam logic [7:0] RD_LAST = 8'(READOUT_CYC - 1);

    exp_state_t state_q, state_d;
    logic       start_prev, inc_prev, dec_prev;
    logic       start_rise, inc_rise, dec_rise;
    logic [4:0] ms_left, ms_d;
    logic [7:0] rd_cnt, rd_d;
    logic [4:0] exp_d;
    logic       ovf5_d, ovf4_d;
    logic       clr, tick;

    assign start_rise = Start_Timer  & ~start_prev;
    assign inc_rise   = Exp_increase & ~inc_prev;
    assign dec_rise   = Exp_decrease & ~dec_prev;
    assign State_dbg  = state_q;

    ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (clr),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        ms_d    = ms_left;
        rd_d    = rd_cnt;
        ovf5_d  = 1'b0;
        ovf4_d  = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d = EXPOSE;
                    ms_d    = Exp_time;
                    clr     = 1'b1;
                end
            end
            EXPOSE: begin
                // ms_left counts the ms still to run, including the current one
                if (tick) begin
                    if (ms_left == 5'd1) begin
                        ovf5_d  = 1'b1;
                        state_d = READOUT;
                        rd_d    = '0;
                    end else begin
                        ms_d = ms_left - 5'd1;
                    end
                end
            end
            READOUT: begin
                if (rd_cnt == RD_LAST) begin
                    ovf4_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    rd_d = rd_cnt + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Init dominates; simultaneous inc/dec edges cancel; out-of-range steps are dropped
    always_comb begin
        exp_d = Exp_time;
        if (Init) begin
            exp_d = EXP_INIT;
        end else if (inc_rise && dec_rise) begin
            exp_d = Exp_time;
        end else if (inc_rise && (Exp_time < EXP_MAX)) begin
            exp_d = Exp_time + 5'd1;
        end else if (dec_rise && (Exp_time > EXP_MIN)) begin
            exp_d = Exp_time - 5'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            start_prev <= 1'b0;
            inc_prev   <= 1'b0;
            dec_prev   <= 1'b0;
            ms_left    <= '0;
            rd_cnt     <= '0;
            Ovf5       <= 1'b0;
            Ovf4       <= 1'b0;
            Busy       <= 1'b0;
            Exp_time   <= EXP_INIT;
        end else begin
            state_q    <= state_d;
            start_prev <= Start_Timer;
            inc_prev   <= Exp_increase;
            dec_prev   <= Exp_decrease;
            ms_left    <= ms_d;
            rd_cnt     <= rd_d;
            Ovf5       <= ovf5_d;
            Ovf4       <= ovf4_d;
            Busy       <= (state_q != IDLE);
            Exp_time   <= exp_d;
        end
    end

endmodule

// File: doc/exposure_timer.md
EXPOSURE_TIMER -- requirements
Module: exposure_timer

Interface
REQ-001 SHALL have parameter CLK_PER_MS, default 1000, Clk cycles per 1 ms tick (range 2..65535).
REQ-002 SHALL have parameter READOUT_CYC, default 16, Clk cycles in the readout window (range 1..255).
REQ-003 SHALL have port Clk  in  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start_Timer  in  1  exposure start request from the exposure controller.
REQ-006 SHALL have port Init  in  1  synchronous load of Exp_time to EXP_INIT.
REQ-007 SHALL have port Exp_increase  in  1  level input; each rising edge adds 1 ms.
REQ-008 SHALL have port Exp_decrease  in  1  level input; each rising edge subtracts 1 ms.
REQ-009 SHALL have port Ovf5  out  1  one-cycle pulse at end of exposure.
REQ-010 SHALL have port Ovf4  out  1  one-cycle pulse at end of readout window.
REQ-011 SHALL have port Exp_time  out  5  current exposure setting in ms.
REQ-012 SHALL have port Busy  out  1  high while a timing sequence is in progress.

Function
REQ-013 SHALL implement states IDLE, EXPOSE, READOUT.
REQ-014 SHALL edge-detect Start_Timer, Exp_increase and Exp_decrease with one registered copy each; a rising edge is current=1 and previous=0.
REQ-015 In IDLE, a Start_Timer rising edge sampled at edge N SHALL move to EXPOSE, latch Exp_time, clear the tick prescaler, and set Busy from cycle N+1.
REQ-016 Ovf5 SHALL be high for exactly the one cycle after edge N + Exp_time_latched*CLK_PER_MS; the FSM SHALL enter READOUT on the same edge.
REQ-017 Ovf4 SHALL be high for exactly one cycle, READOUT_CYC cycles after the Ovf5 cycle; the FSM SHALL return to IDLE on the same edge, and Busy SHALL drop the cycle after Ovf4.
REQ-018 Start_Timer edges in EXPOSE or READOUT SHALL be ignored; Start_Timer held high across the return to IDLE SHALL NOT retrigger.
REQ-019 Exp_time SHALL be updated in every state; changes during EXPOSE SHALL NOT alter the latched duration.
REQ-020 Exp_time update priority SHALL be: Init (load EXP_INIT=15) > increase and decrease edges in the same cycle (no change) > single edge (+/-1).
REQ-021 Exp_time SHALL saturate at EXP_MIN=2 and EXP_MAX=30; an edge that would leave this range SHALL be a no-op.
REQ-022 Ovf5 and Ovf4 SHALL never be high in the same cycle, and SHALL be 0 in IDLE.

Reset
REQ-023 Reset low SHALL immediately force: state IDLE, Ovf5=0, Ovf4=0, Busy=0, Exp_time=15, prescaler=0, edge-detect registers=0.
REQ-024 Reset asserted during EXPOSE or READOUT SHALL abort the sequence with no Ovf pulse; after Reset rises, the first Start_Timer rising edge SHALL start a full-length exposure.

Structure
REQ-025 The state type and the constants EXP_MIN, EXP_MAX and EXP_INIT SHALL reside in the shared package cam_pkg, which the exposure controller also uses.
REQ-026 The ms prescaler SHALL be a sub-module ms_tick_gen with inputs Clk, Reset and clr, output tick, and parameter CLK_PER_MS.
REQ-027 Total RTL SHALL be 120-400 lines, with no latches and no combinational path from any input to Ovf5 or Ovf4.

Verification (CLK_PER_MS=4, READOUT_CYC=3)
REQ-028 Reset, then a Start_Timer pulse at edge N with Exp_time=15 -> Ovf5 high in cycle N+60, Ovf4 high in cycle N+63, Busy high in cycles N+1..N+63.
REQ-029 20 Exp_increase pulses from 15 -> Exp_time=30; then 40 Exp_decrease pulses -> Exp_time=2; no wrap-around.
REQ-030 Exp_increase and Exp_decrease rising in the same cycle -> Exp_time unchanged; Init together with Exp_increase -> Exp_time=15.
REQ-031 Start at Exp_time=10, then 3 Exp_decrease pulses and a second Start_Timer pulse mid-exposure -> Ovf5 still at N+40, Exp_time=7, exactly one Ovf5/Ovf4 pair.
REQ-032 Reset low at N+20 of an exposure -> all outputs 0 and Exp_time=15 immediately, no Ovf5; a new Start_Timer pulse after reset release gives full 60-cycle exposure.
REQ-033 Start_Timer held high continuously from N -> exactly one sequence, Busy low after N+63 until Start_Timer goes low and then high again.
